wb_stage_reg: RTL and testbench
===============================

# wb_stage_reg

Parametrised MEM→WB pipeline register for the MIPS core, successor to the fixed 32-bit stage register. It carries a valid bit, a clearable payload, an instruction word and a sticky PC field, with stall (hold) and flush (bubble) control. Interrupt-driven clears are suppressed while an ERET is in decode or execute. Two saturating performance counters record bubbles and stall cycles. It sits between the data-memory stage and the register-file write-back logic.

## Interface
- DATA_W, 64: clearable payload width (ALU result and DM read data, concatenated).
- KEEP_W, 32: sticky payload width (PC+8); preserved across flushes.
- INSTR_W, 32: instruction word width.
- ERET_CODE, 32'h42000018: encoding that exempts a clear.
- CNT_W, 16: performance counter width.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold the current contents.
- flush  input  1  insert a bubble unconditionally.
- intclr  input  1  interrupt/exception clear request.
- instr_d  input  INSTR_W  instruction in decode (ERET check).
- instr_e  input  INSTR_W  instruction in execute (ERET check).
- in_valid  input  1  the MEM-stage slot holds a real instruction.
- in_instr  input  INSTR_W  MEM-stage instruction.
- in_data  input  DATA_W  MEM-stage clearable payload.
- in_keep  input  KEEP_W  MEM-stage sticky payload.
- out_valid  output  1  WB slot is valid.
- out_instr  output  INSTR_W  WB instruction.
- out_data  output  DATA_W  WB payload.
- out_keep  output  KEEP_W  WB sticky payload.
- cnt_clr  input  1  synchronous clear of both counters.
- bubble_cnt  output  CNT_W  count of bubbles captured.
- stall_cnt  output  CNT_W  count of stall cycles.

## Operation
- eret_hit = (instr_d == ERET_CODE) | (instr_e == ERET_CODE).
- clr = flush | (intclr & ~eret_hit).
- Per-edge priority is reset > clr > stall > load.
- **clr**: out_valid, out_instr and out_data go to 0. out_keep holds, so the EPC source survives.
- **stall** (no clr): all outputs hold.
- **load**: out_valid <= in_valid and out_keep <= in_keep. out_instr and out_data take the inputs when in_valid=1, or 0 when in_valid=0 (canonical bubble).
- bubble_cnt increments on every edge where clr is active, or where a load occurs with in_valid=0.
- stall_cnt increments on every edge where stall=1 and clr=0.
- Both counters saturate at all-ones and never wrap.
- cnt_clr sets both counters to 0 and overrides any same-cycle increment. cnt_clr does not affect the pipeline fields.

## Timing
- Latency is one clock from inputs to outputs. There are no combinational paths from inputs to outputs.
- Reset (asynchronous assert, synchronous release): every output, including out_keep and both counters, is 0 while reset=0.
- Reset asserted mid-stall or mid-flush takes effect immediately. The first edge after release performs a normal evaluation.
- stall and flush together: flush wins and one bubble is inserted. stall_cnt does not increment; bubble_cnt does.
- intclr with eret_hit=1 is ignored completely. The edge then behaves as stall or load.
- A counter at all-ones with an increment condition stays at all-ones.

## Structure
- The shared core package holds ERET_CODE and the NOP/bubble constant (32'h0). Those defaults also serve the other stage registers.
- One sub-module, sat_counter (parameter CNT_W; ports clk, reset, clr, inc, count), is instantiated twice.
- The datapath register is inline in wb_stage_reg.

## Test plan
- **Reset:** hold reset=0 with nonzero inputs → all outputs 0. Release, then load in_valid=1, instr=32'h8C080004, data=64'h1234, keep=32'h3008 → those values appear after one edge.
- **Stall:** stall=1 for 3 cycles while the inputs change → outputs hold the prior values and stall_cnt=3.
- **Clear exemption:** intclr=1 with instr_e=32'h42000018 → outputs load normally and bubble_cnt is unchanged. Repeat with instr_d=instr_e=0 → out_valid, out_instr and out_data are 0, out_keep is 32'h3008, and bubble_cnt increments by 1.
- **Flush over stall:** flush=1 and stall=1 on the same edge → bubble inserted, bubble_cnt+1, stall_cnt unchanged.
- **Saturation (CNT_W=4):** 20 consecutive bubbles → bubble_cnt=15. Then cnt_clr=1 together with a bubble → 0.
- **Asynchronous reset mid-stall:** assert reset between clock edges during a stall → outputs go to 0 before the next edge.

Source files
------------

// File: rtl/wb_stage_reg_pkg.sv
// Shared core constants for the pipeline stage registers.
package wb_stage_reg_pkg;

   // ERET encoding; while it sits in decode or execute, interrupt clears are ignored.
   localparam logic [31:0] CORE_ERET_CODE = 32'h42000018;

   // Canonical bubble instruction.
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Clear has priority over increment; the count sticks at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register: valid bit, clearable payload, instruction word,
// sticky PC field, stall/flush control and bubble/stall performance counters.
module wb_stage_reg
   import wb_stage_reg_pkg::*;
#(
   parameter int unsigned          DATA_W    = 64,
   parameter int unsigned          KEEP_W    = 32,
   parameter int unsigned          INSTR_W   = 32,
   parameter logic [INSTR_W-1:0]   ERET_CODE = INSTR_W'(CORE_ERET_CODE),
   parameter int unsigned          CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               intclr,
   input  logic [INSTR_W-1:0] instr_d,
   input  logic [INSTR_W-1:0] instr_e,
   input  logic               in_valid,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [DATA_W-1:0]  in_data,
   input  logic [KEEP_W-1:0]  in_keep,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [DATA_W-1:0]  out_data,
   output logic [KEEP_W-1:0]  out_keep,
   input  logic               cnt_clr,
   output logic [CNT_W-1:0]   bubble_cnt,
   output logic [CNT_W-1:0]   stall_cnt
);

   logic eretHit;
   logic clr;
   logic bubbleInc;
   logic stallInc;

   // Decode the clear request and the counter increment conditions.
   always_comb begin
      eretHit   = (instr_d == ERET_CODE) || (instr_e == ERET_CODE);
      clr       = flush || (intclr && !eretHit);
      bubbleInc = clr || (!stall && !in_valid);
      stallInc  = stall && !clr;
   end

   // Stage register: clear beats stall beats load; out_keep survives a clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_instr <= '0;
         out_data  <= '0;
         out_keep  <= '0;
      end else if (clr) begin
         out_valid <= 1'b0;
         out_instr <= INSTR_W'(NOP_INSTR);
         out_data  <= '0;
      end else if (!stall) begin
         out_valid <= in_valid;
         out_keep  <= in_keep;
         out_instr <= in_valid ? in_instr : INSTR_W'(NOP_INSTR);
         out_data  <= in_valid ? in_data  : '0;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) uBubbleCnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (bubbleInc),
      .count (bubble_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) uStallCnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (stallInc),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed self-checking bench for wb_stage_reg (4-bit counters to reach saturation).
module tb_wb_stage_reg;

   localparam int unsigned CW = 4;

   logic          clk;
   logic          reset;
   logic          stall;
   logic          flush;
   logic          intclr;
   logic [31:0]   instr_d;
   logic [31:0]   instr_e;
   logic          in_valid;
   logic [31:0]   in_instr;
   logic [63:0]   in_data;
   logic [31:0]   in_keep;
   logic          out_valid;
   logic [31:0]   out_instr;
   logic [63:0]   out_data;
   logic [31:0]   out_keep;
   logic          cnt_clr;
   logic [CW-1:0] bubble_cnt;
   logic [CW-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   wb_stage_reg #(.DATA_W(64), .KEEP_W(32), .INSTR_W(32), .ERET_CODE(32'h42000018), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .flush      (flush),
      .intclr     (intclr),
      .instr_d    (instr_d),
      .instr_e    (instr_e),
      .in_valid   (in_valid),
      .in_instr   (in_instr),
      .in_data    (in_data),
      .in_keep    (in_keep),
      .out_valid  (out_valid),
      .out_instr  (out_instr),
      .out_data   (out_data),
      .out_keep   (out_keep),
      .cnt_clr    (cnt_clr),
      .bubble_cnt (bubble_cnt),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOut(input string tag, input logic v, input logic [31:0] ins,
                           input logic [63:0] d, input logic [31:0] k);
      check({tag, ".valid"}, 64'(out_valid), 64'(v));
      check({tag, ".instr"}, 64'(out_instr), 64'(ins));
      check({tag, ".data"},  out_data, d);
      check({tag, ".keep"},  64'(out_keep), 64'(k));
   endtask

   task automatic checkCnt(input string tag, input int b, input int s);
      check({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(b));
      check({tag, ".stall_cnt"},  64'(stall_cnt),  64'(s));
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; flush = 1'b0; intclr = 1'b0; cnt_clr = 1'b0;
      instr_d = '0; instr_e = '0;
      in_valid = 1'b1; in_instr = 32'hDEADBEEF; in_data = 64'hFFFF_0000_FFFF_0000; in_keep = 32'h5555AAAA;

      // Reset held with nonzero inputs
      step(); step();
      checkOut("reset", 1'b0, 32'h0, 64'h0, 32'h0);
      checkCnt("reset", 0, 0);
      reset = 1'b1;

      // First load after release
      in_valid = 1'b1; in_instr = 32'h8C080004; in_data = 64'h1234; in_keep = 32'h3008;
      step();
      checkOut("load1", 1'b1, 32'h8C080004, 64'h1234, 32'h3008);
      checkCnt("load1", 0, 0);

      // Stall for three cycles with changing inputs
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_instr = 32'h1000 + i; in_data = 64'h9999 + i; in_keep = 32'h4000 + i; in_valid = i[0];
         step();
         checkOut("stall", 1'b1, 32'h8C080004, 64'h1234, 32'h3008);
      end
      checkCnt("stall", 0, 3);
      stall = 1'b0;

      // intclr exempted by ERET in execute: loads normally
      intclr = 1'b1; instr_e = 32'h42000018;
      in_valid = 1'b1; in_instr = 32'h01095020; in_data = 64'hABCD; in_keep = 32'h3008;
      step();
      checkOut("eret_e", 1'b1, 32'h01095020, 64'hABCD, 32'h3008);
      checkCnt("eret_e", 0, 3);

      // intclr without ERET: clear, keep survives
      instr_e = 32'h0; instr_d = 32'h0; in_keep = 32'h7777;
      step();
      checkOut("intclr", 1'b0, 32'h0, 64'h0, 32'h3008);
      checkCnt("intclr", 1, 3);

      // intclr exempted by ERET in decode while stalled: behaves as a stall
      instr_d = 32'h42000018; stall = 1'b1;
      step();
      checkOut("eret_d_stall", 1'b0, 32'h0, 64'h0, 32'h3008);
      checkCnt("eret_d_stall", 1, 4);
      intclr = 1'b0; instr_d = 32'h0; stall = 1'b0;

      // Reload, then flush together with stall
      in_valid = 1'b1; in_instr = 32'h8C080004; in_data = 64'h1234; in_keep = 32'h3020;
      step();
      checkOut("reload", 1'b1, 32'h8C080004, 64'h1234, 32'h3020);
      flush = 1'b1; stall = 1'b1; in_keep = 32'h3030;
      step();
      checkOut("flush_stall", 1'b0, 32'h0, 64'h0, 32'h3020);
      checkCnt("flush_stall", 2, 4);
      flush = 1'b0; stall = 1'b0;

      // Load with in_valid=0: canonical bubble, keep still loads
      in_valid = 1'b0; in_instr = 32'hCAFEF00D; in_data = 64'h5A5A; in_keep = 32'h3040;
      step();
      checkOut("bubble_load", 1'b0, 32'h0, 64'h0, 32'h3040);
      checkCnt("bubble_load", 3, 4);

      // Saturation: 20 further bubbles pin the 4-bit counter at 15
      flush = 1'b1;
      for (int i = 0; i < 20; i++) step();
      checkCnt("saturate", 15, 4);

      // cnt_clr overrides a same-cycle bubble increment
      cnt_clr = 1'b1;
      step();
      checkCnt("cnt_clr", 0, 0);
      cnt_clr = 1'b0; flush = 1'b0;

      // Asynchronous reset between edges during a stall
      in_valid = 1'b1; in_instr = 32'h8C080004; in_data = 64'h1234; in_keep = 32'h3008;
      step();
      checkOut("pre_areset", 1'b1, 32'h8C080004, 64'h1234, 32'h3008);
      stall = 1'b1;
      step();
      #3 reset = 1'b0;
      #1;
      checkOut("areset", 1'b0, 32'h0, 64'h0, 32'h0);
      checkCnt("areset", 0, 0);
      #1 reset = 1'b1;

      // First edge after release evaluates normally (stall still high: hold zeros)
      step();
      checkOut("post_release", 1'b0, 32'h0, 64'h0, 32'h0);
      checkCnt("post_release", 0, 1);
      stall = 1'b0;
      step();
      checkOut("post_release_load", 1'b1, 32'h8C080004, 64'h1234, 32'h3008);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
